// File: rtl/muldiv_alu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// comparison flags (common with the ALU) and controller states.
package muldiv_alu_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    localparam logic [1:0] CMP_EQUAL   = 2'b00;
    localparam logic [1:0] CMP_GREATER = 2'b01;
    localparam logic [1:0] CMP_LESS    = 2'b10;
    localparam logic [1:0] CMP_OTHER   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic [1:0] cmp_of(input logic is_zero, input logic msb);
        if (is_zero)  return CMP_EQUAL;
        else if (msb) return CMP_LESS;
        else          return CMP_GREATER;
    endfunction

endpackage

// File: rtl/md_signfix.sv
// Conditional two's-complement negate; gives |x| on the way in and restores
// the sign of the product/quotient/remainder on the way out.
module md_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/muldiv_alu.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add multiply
// and restoring divide sharing a single WIDTH+1 bit adder.
module muldiv_alu
    import muldiv_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       cmp
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q, op_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         cmp_q, cmp_d;

    md_op_e             op_in;
    logic               signed_a, signed_b, sa, sb, neg_in;
    logic               b_zero, ovf, fast;
    logic [WIDTH-1:0]   abs_a, abs_b, fast_res;
    logic [WIDTH:0]     shifted, add_a, add_b, add_sum;
    logic               add_cin;
    logic [WIDTH-1:0]   div_sel, res_fix;
    logic [2*WIDTH-1:0] fix_in, fix_out;

    // Operand decode for the accepting cycle
    assign op_in    = md_op_e'(md_op);
    assign signed_a = (op_in == MD_MUL) || (op_in == MD_MULH) || (op_in == MD_MULHSU)
                   || (op_in == MD_DIV) || (op_in == MD_REM);
    assign signed_b = (op_in == MD_MUL) || (op_in == MD_MULH)
                   || (op_in == MD_DIV) || (op_in == MD_REM);
    assign sa       = signed_a & operandA[WIDTH-1];
    assign sb       = signed_b & operandB[WIDTH-1];
    // Remainder follows the dividend; everything else follows the sign product
    assign neg_in   = (op_in == MD_REM) ? sa : (sa ^ sb);

    assign b_zero = (operandB == '0);
    assign ovf    = ((op_in == MD_DIV) || (op_in == MD_REM))
                 && (operandA == MIN_VAL) && (&operandB);
    assign fast   = op_in[2] && (b_zero || ovf);

    always_comb begin
        fast_res = '0;
        if (b_zero) fast_res = op_in[1] ? operandA : '1;
        else        fast_res = op_in[1] ? '0 : MIN_VAL;
    end

    md_signfix #(.W(WIDTH)) u_abs_a (.val_i(operandA), .neg_i(sa), .val_o(abs_a));
    md_signfix #(.W(WIDTH)) u_abs_b (.val_i(operandB), .neg_i(sb), .val_o(abs_b));

    // Shared adder: add multiplicand into the high half, or trial-subtract divisor
    assign shifted = {rem_q, prod_q[WIDTH-1]};

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (op_q[2]) begin
            add_a   = shifted;
            add_b   = ~{1'b0, opb_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
            add_b   = prod_q[0] ? {1'b0, opb_q} : '0;
        end
    end

    assign add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};

    // Output sign correction and half selection
    assign div_sel = op_q[1] ? rem_q : prod_q[WIDTH-1:0];
    assign fix_in  = op_q[2] ? {{WIDTH{1'b0}}, div_sel} : prod_q;

    md_signfix #(.W(2*WIDTH)) u_fix (.val_i(fix_in), .neg_i(neg_q), .val_o(fix_out));

    assign res_fix = (op_q[2] || (op_q[1:0] == 2'b00)) ? fix_out[WIDTH-1:0]
                                                        : fix_out[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        result_d = result_q;
        cmp_d    = cmp_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start) begin
                    op_d  = op_in;
                    neg_d = neg_in;
                    if (fast) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                        cmp_d    = cmp_of(fast_res == '0, fast_res[WIDTH-1]);
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        prod_d  = {{WIDTH{1'b0}}, (op_in[2] ? abs_a : abs_b)};
                        opb_d   = op_in[2] ? abs_b : abs_a;
                        rem_d   = '0;
                    end
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    // Non-negative trial difference means the divisor fits
                    if (!add_sum[WIDTH]) begin
                        rem_d              = add_sum[WIDTH-1:0];
                        prod_d[WIDTH-1:0]  = {prod_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d              = shifted[WIDTH-1:0];
                        prod_d[WIDTH-1:0]  = {prod_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    prod_d = {add_sum, prod_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_FIX: begin
                state_d  = S_DONE;
                result_d = res_fix;
                cmp_d    = cmp_of(res_fix == '0, res_fix[WIDTH-1]);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            cmp_q    <= CMP_EQUAL;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cmp_q    <= cmp_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        neg_q  <= neg_d;
        prod_q <= prod_d;
        rem_q  <= rem_d;
        opb_q  <= opb_d;
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cmp    = cmp_q;

endmodule

// File: doc/muldiv_alu.md
Name: muldiv_alu

Overview:
- Multi-cycle, parametrised multiply/divide unit; companion to the single-cycle ALU, extending the datapath with RV32M semantics.
- Iterative design: one bit per cycle, shift-add multiplier and restoring divider sharing one adder.
- Sits beside the ALU in EX; the controller stalls the pipeline/PC while busy=1.
- Result is qualified by a one-cycle done pulse and held until the next accepted start.

Parameters:
- WIDTH, 32, operand/result width; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; accepted only when busy=0.
- md_op  in  3  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (codes in param.v).
- operandA  in  WIDTH  rs1 / dividend.
- operandB  in  WIDTH  rs2 / divisor.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; result valid from this cycle.
- result  out  WIDTH  registered result; held until the next accepted start.
- cmp  out  2  `EQUAL if result==0, `GREATER if result MSB=0, `LESS if MSB=1; registered with result.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, cmp=`EQUAL, counter=0. Reset has priority over every other event, including mid-operation; it aborts silently with no done pulse.
- Acceptance:
  - start && !busy at edge E0 latches md_op, operands and sign flags.
  - Inputs are ignored after E0.
  - start while busy=1 is ignored and not queued.
  - start in the same cycle as done is accepted (back-to-back).
- States:
  - IDLE: waits for start.
  - CALC: WIDTH iterations; counter counts WIDTH-1 down to 0.
  - FIX: sign correction and upper/lower selection.
  - DONE: pulses done, then returns to IDLE.
- Transitions:
  - IDLE -> CALC on accept.
  - IDLE -> DONE on accept of a fast-path case.
  - CALC -> FIX when counter==0.
  - FIX -> DONE.
  - DONE -> IDLE, or DONE -> CALC/DONE if a new start is accepted.
- Latency: normal ops give done in cycle E0+WIDTH+2 (34 for WIDTH=32). Fast paths give done in cycle E0+1.
- Fast paths:
  - Divisor==0: DIV/DIVU result all-ones; REM/REMU result = operandA.
  - Signed overflow (DIV/REM, A=MIN, B=-1): DIV result = MIN; REM result = 0.
- Arithmetic:
  - Signed operands are converted to magnitude in IDLE; unsigned magnitude iteration uses a 2*WIDTH product register and a WIDTH+1 bit partial remainder.
  - MUL returns the low WIDTH bits; MULH, MULHSU and MULHU return the high WIDTH bits.
  - MULHSU: A signed, B unsigned.
  - Product negated in FIX iff the operand signs differ (MULHSU: iff A is negative).
  - Quotient negated iff the signs differ; remainder takes the dividend's sign.
  - Quotient truncates toward zero.
- done, result and cmp update in the same cycle.
- busy=0 in IDLE, and in DONE unless a new start is accepted.

Decomposition:
- param.v holds:
  - md_op codes: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - cmp codes: `EQUAL, `GREATER, `LESS, `OTHER, shared with the ALU.
  - state encodings S_IDLE, S_CALC, S_FIX, S_DONE.
- One natural sub-module, md_signfix: combinational magnitude/negate helper, used for the input abs and the output correction.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB, cmp=`LESS, done exactly 34 cycles after the start edge, busy high for cycles 1..33.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000 with cmp=`EQUAL. MULHSU same operands -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done 1 cycle after start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0, both 1-cycle.
- Hold start high with new operands during busy -> result is unchanged and no extra done. Start asserted in the done cycle -> second op accepted, second done 34 cycles later.
- Assert rst at cycle 10 of a MUL -> next cycle busy=0, result=0, cmp=`EQUAL, no done. A following DIVU 9/3 completes with result 3.
